// File: rtl/stack_pkg.sv
// Shared types for the guarded LIFO stack: opcodes, error codes and the
// minimum-occupancy table used by the legality guard.
package stack_pkg;

  typedef enum logic [3:0] {
    OP_PUSH        = 4'd0,
    OP_REPLACE     = 4'd1,
    OP_DROP2       = 4'd2,
    OP_POP_REPLACE = 4'd3,
    OP_DROP        = 4'd4,
    OP_DUP         = 4'd5,
    OP_SWAP        = 4'd6,
    OP_OVER        = 4'd7,
    OP_CLEAR       = 4'd8
  } stack_op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } stack_err_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd8;

  // Entries an op must find on the stack before it may execute.
  function automatic logic [1:0] min_count(input stack_op_e op);
    logic [1:0] n;
    case (op)
      OP_PUSH, OP_CLEAR:                         n = 2'd0;
      OP_REPLACE, OP_DROP, OP_DUP:               n = 2'd1;
      OP_DROP2, OP_POP_REPLACE, OP_SWAP, OP_OVER: n = 2'd2;
      default:                                   n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stack_guard.sv
// Combinational legality check for one stack op: classifies errors with
// underflow taking priority over overflow, and computes the next occupancy.
module stack_guard
  import stack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic [3:0]    op,
  input  logic [CW-1:0] count,
  output logic          legal,
  output logic [1:0]    err_code,
  output logic [CW-1:0] count_next
);

  stack_op_e  op_e_s;
  stack_err_e err_s;
  logic       grows_s;

  assign op_e_s   = stack_op_e'(op);
  assign err_code = err_s;

  // Growth ops are the only ones that can overflow.
  always_comb begin
    grows_s = 1'b0;
    case (op_e_s)
      OP_PUSH, OP_DUP, OP_OVER: grows_s = 1'b1;
      default:                  grows_s = 1'b0;
    endcase
  end

  // Classify the op and derive the occupancy it would leave behind.
  always_comb begin
    legal      = 1'b0;
    err_s      = ERR_NONE;
    count_next = count;
    if (op > OP_LAST_LEGAL) begin
      err_s = ERR_ILLEGAL;
    end else if (count < CW'(min_count(op_e_s))) begin
      err_s = ERR_UNDERFLOW;
    end else if (grows_s && (count == CW'(DEPTH))) begin
      err_s = ERR_OVERFLOW;
    end else begin
      legal = 1'b1;
      case (op_e_s)
        OP_PUSH, OP_DUP, OP_OVER:   count_next = count + CW'(1);
        OP_DROP2:                   count_next = count - CW'(2);
        OP_POP_REPLACE, OP_DROP:    count_next = count - CW'(1);
        OP_CLEAR:                   count_next = {CW{1'b0}};
        default:                    count_next = count;
      endcase
    end
  end

endmodule

// File: rtl/guarded_stack.sv
// Parametrised LIFO with Forth-style ops, occupancy/high-water reporting and
// sticky error capture; rejected ops leave storage and occupancy untouched.
module guarded_stack
  import stack_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] stack_top,
  output logic [WIDTH-1:0] stack_next,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    hwm,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_pulse
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] count_r;
  logic [CW-1:0] hwm_r;
  logic          err_r;
  logic [1:0]    err_code_r;
  logic          err_pulse_r;

  logic          legal_s;
  logic [1:0]    guard_err_s;
  logic [CW-1:0] count_next_s;
  logic          exec_s;
  logic          reject_s;
  logic [AW-1:0] push_idx_s;
  logic [AW-1:0] top_idx_s;
  logic [AW-1:0] next_idx_s;
  logic [WIDTH-1:0] top_raw_s;
  logic [WIDTH-1:0] next_raw_s;

  stack_guard #(.DEPTH(DEPTH), .CW(CW)) u_guard (
    .op         (op),
    .count      (count_r),
    .legal      (legal_s),
    .err_code   (guard_err_s),
    .count_next (count_next_s)
  );

  assign exec_s   = en & legal_s;
  assign reject_s = en & ~legal_s;

  // Index arithmetic wraps for short stacks; those reads are gated below.
  assign push_idx_s = AW'(count_r);
  assign top_idx_s  = AW'(count_r - CW'(1));
  assign next_idx_s = AW'(count_r - CW'(2));
  assign top_raw_s  = mem[top_idx_s];
  assign next_raw_s = mem[next_idx_s];

  assign stack_top  = (count_r >= CW'(1)) ? top_raw_s  : {WIDTH{1'b0}};
  assign stack_next = (count_r >= CW'(2)) ? next_raw_s : {WIDTH{1'b0}};
  assign count      = count_r;
  assign hwm        = hwm_r;
  assign empty      = (count_r == {CW{1'b0}});
  assign full       = (count_r == CW'(DEPTH));
  assign err        = err_r;
  assign err_code   = err_code_r;
  assign err_pulse  = err_pulse_r;

  // Storage writes for accepted ops; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (exec_s) begin
      case (stack_op_e'(op))
        OP_PUSH:        mem[push_idx_s] <= data_in;
        OP_REPLACE:     mem[top_idx_s]  <= data_in;
        OP_POP_REPLACE: mem[next_idx_s] <= data_in;
        OP_DUP:         mem[push_idx_s] <= top_raw_s;
        OP_OVER:        mem[push_idx_s] <= next_raw_s;
        OP_SWAP: begin
          mem[top_idx_s]  <= next_raw_s;
          mem[next_idx_s] <= top_raw_s;
        end
        default: ;
      endcase
    end
  end

  // Occupancy and high-water mark; CLEAR lowers count but never hwm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
      hwm_r   <= {CW{1'b0}};
    end else if (exec_s) begin
      count_r <= count_next_s;
      if (count_next_s > hwm_r) begin
        hwm_r <= count_next_s;
      end
    end
  end

  // Sticky error: first error wins unless cleared in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
      err_pulse_r <= 1'b0;
    end else begin
      err_pulse_r <= reject_s;
      if (reject_s && (!err_r || clr_err)) begin
        err_r      <= 1'b1;
        err_code_r <= guard_err_s;
      end else if (clr_err) begin
        err_r      <= 1'b0;
        err_code_r <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_guarded_stack.sv
// Directed bench for guarded_stack (WIDTH=8, DEPTH=4) with hand-computed
// expectations checked by immediate assertions.
module tb_guarded_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst;
  logic             en;
  logic [3:0]       op;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH-1:0] stack_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    hwm;
  logic             empty;
  logic             full;
  logic             err;
  logic [1:0]       err_code;
  logic             err_pulse;

  int checks = 0;
  int errors = 0;

  guarded_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .op         (op),
    .data_in    (data_in),
    .clr_err    (clr_err),
    .stack_top  (stack_top),
    .stack_next (stack_next),
    .count      (count),
    .hwm        (hwm),
    .empty      (empty),
    .full       (full),
    .err        (err),
    .err_code   (err_code),
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic e, input logic [3:0] o, input logic [7:0] d, input logic c);
    @(negedge clk);
    en = e; op = o; data_in = d; clr_err = c;
    @(posedge clk);
    #1;
    en = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; op = 4'd0; data_in = 8'h00; clr_err = 1'b0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_hwm", hwm, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_top", stack_top, 0);
    chk("rst_next", stack_next, 0);
    @(negedge clk); rst = 1'b0;

    // 1: three pushes
    step(1'b1, 4'd0, 8'h11, 1'b0);
    step(1'b1, 4'd0, 8'h22, 1'b0);
    step(1'b1, 4'd0, 8'h33, 1'b0);
    chk("t1_count", count, 3);
    chk("t1_top", stack_top, 8'h33);
    chk("t1_next", stack_next, 8'h22);
    chk("t1_hwm", hwm, 3);
    chk("t1_empty", empty, 0);

    // 2: fill then overflow
    step(1'b1, 4'd8, 8'h00, 1'b0);
    chk("t2_clear_count", count, 0);
    chk("t2_clear_hwm", hwm, 3);
    step(1'b1, 4'd0, 8'hA0, 1'b0);
    step(1'b1, 4'd0, 8'hA1, 1'b0);
    step(1'b1, 4'd0, 8'hA2, 1'b0);
    step(1'b1, 4'd0, 8'hA3, 1'b0);
    chk("t2_full", full, 1);
    chk("t2_hwm", hwm, 4);
    chk("t2_pulse_before", err_pulse, 0);
    step(1'b1, 4'd0, 8'hFF, 1'b0);
    chk("t2_pulse", err_pulse, 1);
    chk("t2_err", err, 1);
    chk("t2_code", err_code, 1);
    chk("t2_top", stack_top, 8'hA3);
    chk("t2_count", count, 4);
    step(1'b0, 4'd0, 8'h00, 1'b0);
    chk("t2_pulse_one", err_pulse, 0);
    chk("t2_err_sticky", err, 1);

    // 3: POP_REPLACE then DROP2 underflow
    step(1'b0, 4'd0, 8'h00, 1'b1);
    chk("t3_clr_err", err, 0);
    chk("t3_clr_code", err_code, 0);
    chk("t3_clr_count", count, 4);
    step(1'b1, 4'd8, 8'h00, 1'b0);
    step(1'b1, 4'd0, 8'h05, 1'b0);
    step(1'b1, 4'd0, 8'h03, 1'b0);
    step(1'b1, 4'd3, 8'h08, 1'b0);
    chk("t3_count", count, 1);
    chk("t3_top", stack_top, 8'h08);
    chk("t3_next", stack_next, 8'h00);
    step(1'b1, 4'd2, 8'h00, 1'b0);
    chk("t3_code", err_code, 2);
    chk("t3_count_kept", count, 1);
    chk("t3_top_kept", stack_top, 8'h08);

    // 4: SWAP / OVER / DUP / DUP overflow
    step(1'b0, 4'd0, 8'h00, 1'b1);
    step(1'b1, 4'd8, 8'h00, 1'b0);
    step(1'b1, 4'd0, 8'h01, 1'b0);
    step(1'b1, 4'd0, 8'h02, 1'b0);
    step(1'b1, 4'd6, 8'h00, 1'b0);
    chk("t4_swap_top", stack_top, 8'h01);
    chk("t4_swap_next", stack_next, 8'h02);
    step(1'b1, 4'd7, 8'h00, 1'b0);
    chk("t4_over_count", count, 3);
    chk("t4_over_top", stack_top, 8'h02);
    step(1'b1, 4'd5, 8'h00, 1'b0);
    chk("t4_dup_count", count, 4);
    chk("t4_dup_top", stack_top, 8'h02);
    chk("t4_dup_next", stack_next, 8'h02);
    chk("t4_noerr", err, 0);
    step(1'b1, 4'd5, 8'h00, 1'b0);
    chk("t4_dup_code", err_code, 1);
    chk("t4_dup_count_kept", count, 4);

    // 5: illegal op, first-error-wins, clear-with-error
    step(1'b0, 4'd0, 8'h00, 1'b1);
    step(1'b1, 4'd12, 8'h55, 1'b0);
    chk("t5_ill_code", err_code, 3);
    chk("t5_ill_count", count, 4);
    chk("t5_ill_top", stack_top, 8'h02);
    step(1'b1, 4'd8, 8'h00, 1'b0);
    chk("t5_clear_count", count, 0);
    chk("t5_clear_code_held", err_code, 3);
    chk("t5_clear_pulse", err_pulse, 0);
    step(1'b1, 4'd4, 8'h00, 1'b1);
    chk("t5_drop_code", err_code, 2);
    chk("t5_drop_err", err, 1);
    chk("t5_drop_count", count, 0);
    step(1'b1, 4'd9, 8'h00, 1'b0);
    chk("t5_first_wins", err_code, 2);
    chk("t5_hwm", hwm, 4);

    // 6: asynchronous reset mid-cycle, then CLEAR keeps hwm
    step(1'b0, 4'd0, 8'h00, 1'b1);
    step(1'b1, 4'd0, 8'h07, 1'b0);
    step(1'b1, 4'd0, 8'h08, 1'b0);
    step(1'b1, 4'd0, 8'h09, 1'b0);
    step(1'b1, 4'd15, 8'h00, 1'b0);
    chk("t6_pre_count", count, 3);
    chk("t6_pre_pulse", err_pulse, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_top", stack_top, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_hwm", hwm, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_pulse", err_pulse, 0);
    @(negedge clk); rst = 1'b0;
    step(1'b1, 4'd0, 8'h21, 1'b0);
    step(1'b1, 4'd0, 8'h22, 1'b0);
    chk("t6_refill_hwm", hwm, 2);
    step(1'b1, 4'd8, 8'h00, 1'b0);
    chk("t6_clear_count", count, 0);
    chk("t6_clear_hwm", hwm, 2);
    chk("t6_clear_top", stack_top, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
